// File: rtl/dma_controller_mc_if.sv
// Bus-side signals of the multi-channel DMA controller: BR/BG request-grant pair,
// burst completion strobe and the address/offset/length of the current burst.
interface dma_controller_mc_if #(
    parameter int WORD_SIZE = 16
);
    // BR is held high while the DMA wants or owns the bus. A cycle with BR=1 and
    // BG=1 means the bus is granted. In XFER, a cycle with BG=1 and finish=1
    // completes exactly one burst of burst_len words at address_dma + offset.
    logic                 BR;
    logic                 BG;
    logic                 finish;
    logic [WORD_SIZE-1:0] address_dma;
    logic [WORD_SIZE-1:0] offset;
    logic [WORD_SIZE-1:0] burst_len;

    modport master (
        output BR, address_dma, offset, burst_len,
        input  BG, finish
    );

    modport slave (
        input  BR, address_dma, offset, burst_len,
        output BG, finish
    );
endinterface

// File: rtl/dma_controller_mc.sv
// Multi-channel burst DMA controller with round-robin channel arbitration.
// Optional macro DMA_ABORT_EN adds an abort input and a per-channel abort_flag output.
module dma_controller_mc #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_CH    = 2,
    parameter int BURST     = 4,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           start,
    input  logic [NUM_CH*WORD_SIZE-1:0] address,
    input  logic [NUM_CH*WORD_SIZE-1:0] length,
    dma_controller_mc_if.master         bus,
`ifdef DMA_ABORT_EN
    input  logic                        abort,
    output logic [NUM_CH-1:0]           abort_flag,
`endif
    output logic [CH_W-1:0]             active_ch,
    output logic [NUM_CH-1:0]           dma_end_interrupt,
    output logic                        busy,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [NUM_CH-1:0]    r_pending;
    logic [NUM_CH-1:0]    r_irq;
    logic [WORD_SIZE-1:0] r_addr_q [NUM_CH];
    logic [WORD_SIZE-1:0] r_len_q  [NUM_CH];
    logic [WORD_SIZE-1:0] r_addr_dma;
    logic [WORD_SIZE-1:0] r_offset;
    logic [WORD_SIZE-1:0] r_remain;
    logic [CH_W-1:0]      r_active;
    logic [CH_W-1:0]      r_rr_ptr;
    logic                 r_br;
`ifdef DMA_ABORT_EN
    logic [NUM_CH-1:0]    r_abort_flag;
`endif

    logic                 w_sel_valid;
    logic [CH_W-1:0]      w_sel;
    logic [WORD_SIZE-1:0] w_burst_len;
    logic                 w_count;
    logic                 w_last;
    logic                 w_abort;
    logic [NUM_CH-1:0]    w_ch_active;

`ifdef DMA_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // Scan downward so the smallest distance from the pointer wins.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r_pending[rr_idx(r_rr_ptr, k)]) begin
                w_sel_valid = 1'b1;
                w_sel       = rr_idx(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_burst_len = (r_remain > WORD_SIZE'(BURST)) ? WORD_SIZE'(BURST) : r_remain;
        w_count     = bus.BG && bus.finish;
        w_last      = (r_remain == w_burst_len);
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_active[i] = (r_state != S_IDLE) && (r_active == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_irq      <= '0;
            r_addr_dma <= '0;
            r_offset   <= '0;
            r_remain   <= '0;
            r_active   <= '0;
            r_rr_ptr   <= '0;
            r_br       <= 1'b0;
`ifdef DMA_ABORT_EN
            r_abort_flag <= '0;
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                r_addr_q[i] <= '0;
                r_len_q[i]  <= '0;
            end
        end else begin
            r_irq <= '0;
`ifdef DMA_ABORT_EN
            r_abort_flag <= '0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_active   <= w_sel;
                        r_addr_dma <= r_addr_q[w_sel];
                        r_offset   <= '0;
                        r_remain   <= r_len_q[w_sel];
                        // Zero-length requests complete without touching the bus.
                        if (r_len_q[w_sel] == '0) begin
                            r_state      <= S_DONE;
                            r_irq[w_sel] <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_br    <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (w_abort) begin
                        r_state         <= S_DONE;
                        r_br            <= 1'b0;
                        r_irq[r_active] <= 1'b1;
`ifdef DMA_ABORT_EN
                        r_abort_flag[r_active] <= 1'b1;
`endif
                    end else if (bus.BG) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_count) begin
                        r_offset <= r_offset + w_burst_len;
                        r_remain <= r_remain - w_burst_len;
                    end
                    if (w_abort || (w_count && w_last)) begin
                        r_state         <= S_DONE;
                        r_br            <= 1'b0;
                        r_irq[r_active] <= 1'b1;
`ifdef DMA_ABORT_EN
                        if (w_abort) r_abort_flag[r_active] <= 1'b1;
`endif
                    end
                end
                S_DONE: begin
                    r_pending[r_active] <= 1'b0;
                    r_rr_ptr <= (r_active == CH_W'(NUM_CH - 1)) ? '0 : r_active + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // A channel that is queued or being serviced keeps its latched request.
            for (int i = 0; i < NUM_CH; i++) begin
                if (start[i] && !r_pending[i] && !w_ch_active[i]) begin
                    r_pending[i] <= 1'b1;
                    r_addr_q[i]  <= address[i*WORD_SIZE +: WORD_SIZE];
                    r_len_q[i]   <= length[i*WORD_SIZE +: WORD_SIZE];
                end
            end
        end
    end

    assign bus.BR            = r_br;
    assign bus.address_dma   = r_addr_dma;
    assign bus.offset        = r_offset;
    assign bus.burst_len     = w_burst_len;
    assign active_ch         = r_active;
    assign dma_end_interrupt = r_irq;
    assign busy              = (r_state != S_IDLE);
    assign o_dbg_state       = r_state;
`ifdef DMA_ABORT_EN
    assign abort_flag        = r_abort_flag;
`endif

endmodule

// File: tb/tb_dma_controller_mc.sv
// Directed bench for dma_controller_mc (NUM_CH=2, BURST=4, WORD_SIZE=16);
// the abort scenario is included when DMA_ABORT_EN is defined.
module tb_dma_controller_mc;
  localparam int WS = 16;
  localparam int NC = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    start;
  logic [NC*WS-1:0] address;
  logic [NC*WS-1:0] length;
  logic [0:0]       active_ch;
  logic [NC-1:0]    dma_end_interrupt;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef DMA_ABORT_EN
  logic             abort;
  logic [NC-1:0]    abort_flag;
`endif

  dma_controller_mc_if #(.WORD_SIZE(WS)) bus ();

  dma_controller_mc #(.WORD_SIZE(WS), .NUM_CH(NC), .BURST(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .address           (address),
    .length            (length),
    .bus               (bus),
`ifdef DMA_ABORT_EN
    .abort             (abort),
    .abort_flag        (abort_flag),
`endif
    .active_ch         (active_ch),
    .dma_end_interrupt (dma_end_interrupt),
    .busy              (busy),
    .o_dbg_state       (dbg_state)
  );

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [NC-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_ch(input int ch, input logic [WS-1:0] a, input logic [WS-1:0] l);
    address[ch*WS +: WS] = a;
    length[ch*WS +: WS]  = l;
  endtask

  task automatic pulse_start(input logic [NC-1:0] s);
    start = s;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    for (int i = 0; i < budget && dbg_state != st; i++) @(negedge clk);
    check_eq("wait_state", dbg_state, st);
  endtask

  task automatic run_xfer(input int ch, input logic [WS-1:0] addr, input int len, input bit stall);
    int off;
    int blen;
    logic [NC-1:0] exp_irq;
    wait_state(S_XFER, 20);
    check_eq("active_ch", active_ch, ch);
    check_eq("address_dma", bus.address_dma, addr);
    check_eq("br_xfer", bus.BR, 1);
    off = 0;
    while (off < len) begin
      blen = (len - off > 4) ? 4 : len - off;
      check_eq("offset", bus.offset, off);
      check_eq("burst_len", bus.burst_len, blen);
      if (stall && off == 0) begin
        bus.BG = 1'b0;
        bus.finish = 1'b1;
        @(negedge clk);
        check_eq("stall_offset", bus.offset, 0);
        check_eq("stall_state", dbg_state, S_XFER);
        bus.BG = 1'b1;
        bus.finish = 1'b0;
      end
      bus.finish = 1'b1;
      @(negedge clk);
      bus.finish = 1'b0;
      off += blen;
    end
    check_eq("done_state", dbg_state, S_DONE);
    check_eq("br_done", bus.BR, 0);
    check_eq("done_offset", bus.offset, len);
    check_eq("busy_done", busy, 1);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      exp_irq = exp_q.pop_front();
      check_eq("irq", dma_end_interrupt, exp_irq);
    end
    @(negedge clk);
    check_eq("irq_clear", dma_end_interrupt, 0);
    check_eq("idle_after", dbg_state, S_IDLE);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1;
    start = '0;
    address = '0;
    length = '0;
    bus.BG = 1'b1;
    bus.finish = 1'b0;
`ifdef DMA_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);

    check_eq("rst_br", bus.BR, 0);
    check_eq("rst_irq", dma_end_interrupt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_offset", bus.offset, 0);
    check_eq("rst_addr", bus.address_dma, 0);
    check_eq("rst_active", active_ch, 0);

    // start coinciding with reset is dropped
    set_ch(0, 16'h0055, 16'd4);
    start = 2'b01;
    @(negedge clk);
    start = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start_drop", busy, 0);

    // 12 words at 0x0017: three full bursts
    set_ch(0, 16'h0017, 16'd12);
    exp_q.push_back(2'b01);
    pulse_start(2'b01);
    run_xfer(0, 16'h0017, 12, 1'b0);

    // 10 words: 4,4,2 with an ungranted finish in the middle
    set_ch(0, 16'h0100, 16'd10);
    exp_q.push_back(2'b01);
    pulse_start(2'b01);
    run_xfer(0, 16'h0100, 10, 1'b1);

    // reset the round-robin pointer, then serve both channels twice
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_ch(0, 16'h0200, 16'd4);
    set_ch(1, 16'h0300, 16'd5);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    pulse_start(2'b11);
    run_xfer(0, 16'h0200, 4, 1'b0);
    run_xfer(1, 16'h0300, 5, 1'b0);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    pulse_start(2'b11);
    run_xfer(0, 16'h0200, 4, 1'b0);
    run_xfer(1, 16'h0300, 5, 1'b0);

    // zero-length on channel 1: never requests the bus
    set_ch(1, 16'h0400, 16'd0);
    pulse_start(2'b10);
    check_eq("zl_br0", bus.BR, 0);
    @(negedge clk);
    check_eq("zl_state", dbg_state, S_DONE);
    check_eq("zl_irq", dma_end_interrupt, 2'b10);
    check_eq("zl_br1", bus.BR, 0);
    @(negedge clk);
    check_eq("zl_irq_clear", dma_end_interrupt, 0);
    check_eq("zl_br2", bus.BR, 0);

    // reset mid-transfer after one burst
    set_ch(0, 16'h0010, 16'd12);
    pulse_start(2'b01);
    wait_state(S_XFER, 20);
    bus.finish = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    check_eq("mid_offset", bus.offset, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_br", bus.BR, 0);
    check_eq("mid_rst_offset", bus.offset, 0);
    check_eq("mid_rst_irq", dma_end_interrupt, 0);
    check_eq("mid_rst_addr", bus.address_dma, 0);
    repeat (3) @(negedge clk);
    check_eq("mid_rst_no_pending", busy, 0);
    check_eq("mid_rst_no_irq", dma_end_interrupt, 0);
    set_ch(1, 16'h0040, 16'd6);
    exp_q.push_back(2'b10);
    pulse_start(2'b10);
    run_xfer(1, 16'h0040, 6, 1'b0);

`ifdef DMA_ABORT_EN
    set_ch(0, 16'h0020, 16'd12);
    pulse_start(2'b01);
    wait_state(S_XFER, 20);
    bus.finish = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    check_eq("ab_offset", bus.offset, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("ab_state", dbg_state, S_DONE);
    check_eq("ab_irq", dma_end_interrupt, 2'b01);
    check_eq("ab_flag", abort_flag, 2'b01);
    check_eq("ab_br", bus.BR, 0);
    check_eq("ab_offset_hold", bus.offset, 4);
    @(negedge clk);
    check_eq("ab_irq_clear", dma_end_interrupt, 0);
    check_eq("ab_flag_clear", abort_flag, 0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_controller_mc.md
DMA_CONTROLLER_MC -- requirements
Module: dma_controller_mc

Interface
REQ-001 Parameter WORD_SIZE, default 16: address, length and offset width in bits.
REQ-002 Parameter NUM_CH, default 2: number of independent request channels, 1..8.
REQ-003 Parameter BURST, default 4: maximum words per bus burst, a power of two.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset sampled on rising edge of clk.
REQ-006 start  input  NUM_CH  per-channel one-cycle request pulse.
REQ-007 address  input  NUM_CH*WORD_SIZE  per-channel base address, channel i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 length  input  NUM_CH*WORD_SIZE  per-channel transfer length in words, same packing.
REQ-009 BG  input  1  bus grant from CPU.
REQ-010 finish  input  1  device/memory completed the current burst.
REQ-011 BR  output  1  bus request to CPU.
REQ-012 address_dma  output  WORD_SIZE  base address of the active transfer.
REQ-013 offset  output  WORD_SIZE  word offset of the current burst from address_dma.
REQ-014 burst_len  output  WORD_SIZE  words in the current burst, min(BURST, remaining).
REQ-015 active_ch  output  clog2(NUM_CH), min 1  index of the channel being serviced.
REQ-016 dma_end_interrupt  output  NUM_CH  one-cycle completion pulse per channel.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 start[i] SHALL latch address[i] and length[i] and set pending[i] on the same edge.
- A start[i] while pending[i] is already set, or while channel i is active, SHALL be ignored with no relatch.
REQ-019 The FSM SHALL have exactly four states: IDLE, REQ, XFER and DONE.
REQ-020 IDLE SHALL select a channel when any pending bit is set.
- Selection is round-robin, starting from last serviced channel + 1, modulo NUM_CH.
- On selection: load active_ch, load address_dma, set offset=0, set remain=length.
- Next state is REQ, or DONE directly when length is 0, in which case BR is never asserted.
REQ-021 REQ SHALL hold BR=1 and move to XFER on the first cycle BG=1.
REQ-022 XFER SHALL count a burst only on a cycle with BG=1 and finish=1.
- On a counted burst: offset += burst_len, remain -= burst_len.
- When remain reaches 0, next state is DONE.
- finish with BG=0 SHALL be ignored.
REQ-023 burst_len SHALL be combinationally min(BURST, remain), so a partial final burst carries the remainder.
REQ-024 DONE SHALL last one cycle.
- Drive BR=0 and dma_end_interrupt[active_ch]=1.
- Clear pending[active_ch] and record it as last serviced, then return to IDLE.
REQ-025 BR SHALL be 1 exactly in REQ and XFER.
REQ-026 All arithmetic SHALL be modulo 2^WORD_SIZE; address_dma SHALL remain constant for a whole transfer.
REQ-027 A start for a non-active channel arriving in any state SHALL be accepted and queued as pending.

Reset
REQ-028 While reset=1, the block SHALL clear the following on the next edge, including mid-transfer: BR, dma_end_interrupt, offset, address_dma, active_ch, pending, remain, and the round-robin pointer (so channel 0 is first); state SHALL become IDLE.
REQ-029 A start asserted in the same cycle as reset SHALL be discarded.

Configuration
REQ-030 Macro DMA_ABORT_EN, when defined, SHALL add input abort (1 bit).
- abort=1 in REQ or XFER SHALL move to DONE on the next edge and assert the interrupt normally.
- A burst counted in that same cycle SHALL still update offset.
- Output abort_flag (NUM_CH) SHALL pulse alongside dma_end_interrupt for the aborted channel.
REQ-031 Without DMA_ABORT_EN, neither the abort input nor abort_flag SHALL exist, and transfers always run to completion.

Verification
REQ-032 NUM_CH=2, BURST=4: start[0], address=0x0017, length=12, BG tied 1, finish pulsed 3 times -> offset 0,4,8; burst_len 4; BR drops and dma_end_interrupt=2'b01 one cycle after the third finish.
REQ-033 length=10 -> burst_len 4,4,2; offsets 0,4,8; exactly three counted bursts.
REQ-034 start=2'b11 in one cycle -> channel 0 serviced first, then channel 1; interrupts 2'b01 then 2'b10; re-start both -> channel 0 again after channel 1 was last.
REQ-035 length=0 on channel 1 -> BR never rises; dma_end_interrupt=2'b10 two cycles after start.
REQ-036 reset pulsed in XFER after one burst -> BR=0, offset=0, no interrupt, pending=0; a later start on channel 1 runs normally.
REQ-037 With DMA_ABORT_EN: abort in XFER at offset 4 of 12 -> DONE next edge, dma_end_interrupt and abort_flag both 2'b01 for one cycle.
